proc_hier: RTL and testbench
============================

# proc_hier

Single-cycle, 16-bit, 8-register processor core forming the top of the CPU hierarchy. Each clock it fetches one instruction from external instruction memory, executes it and commits register and data-memory writes. It exposes a commit-trace port, which the system bench samples on every rising clock edge to log retired instructions and stop simulation on HALT.

## Interface
- No parameters. Word = 16 bits, byte-addressed PC, instructions 2 bytes.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  16  = PC
- imem_rdata  in  16  instruction at imem_addr (combinational)
- dmem_addr  out  16  data address (ALU result)
- dmem_wdata  out  16  store data
- dmem_wen  out  1  store strobe, memory writes on rising edge
- dmem_ren  out  1  load strobe
- dmem_rdata  in  16  load data (combinational)
- pc  out  16  PC of the committing instruction
- inst  out  16  committing instruction
- reg_write  out  1  register file written this cycle
- write_register  out  3  destination register
- write_data  out  16  value written
- mem_read / mem_write  out  1 each  mirror dmem_ren / dmem_wen
- mem_address / mem_data  out  16 each  mirror dmem_addr / dmem_wdata
- halt  out  1  HALT committing
- cycle_count  out  32  cycles since reset release

## Operation
- Encoding: opcode = inst[15:11], Rs = [10:8], Rd(I) = [7:5], Rt(R) = [7:5], Rd(R) = [4:2], func = [1:0].
- 00000 HALT: halt = 1; PC holds.
- 00001 NOP.
- 01000 ADDI: Rd = Rs + sext(imm5).
- 01001 SUBI: Rd = sext(imm5) − Rs.
- 01010 XORI: Rd = Rs ^ zext(imm5).
- 01011 ANDNI: Rd = Rs & ~zext(imm5).
- 10000 ST: Mem[Rs + sext(imm5)] = Rd.
- 10001 LD: Rd = Mem[Rs + sext(imm5)].
- 10011 STU: Mem[Rs + sext(imm5)] = Rd; Rs = Rs + sext(imm5).
- 11011 R-type:
  - func 00 ADD Rd = Rs + Rt
  - 01 SUB Rd = Rt − Rs
  - 10 XOR
  - 11 ANDN Rd = Rs & ~Rt
- 01100 BEQZ / 01101 BNEZ: if Rs ==/!= 0, PC = PC + 2 + sext(inst[7:0]); otherwise PC + 2.
- 11000 LBI: Rs = sext(inst[7:0]).
- 00100 J: PC = PC + 2 + sext(inst[10:0]).
- Any other opcode executes as NOP.
- Arithmetic is modulo 2^16; no flags or exceptions.
- R0 is an ordinary writable register.
- Trace fields:
  - write_register/write_data equal the actual register-file write port.
  - For STU these are Rs and the incremented address.
  - When reg_write = 0, write_register/write_data are don't-care.
  - mem_data is the store value for ST/STU and don't-care otherwise.

## Timing
- All instructions complete in one cycle. Trace outputs are combinational from the current PC/inst and are valid before the rising edge that commits them.
- Rising edge: PC, register file, data memory and cycle_count update.
- Reset assertion immediately clears PC, all 8 registers and cycle_count to 0; all strobes and trace flags read 0 while reset is low.
- First fetch from address 0 on the first edge after rst_n rises. cycle_count increments on every subsequent edge.
- HALT:
  - PC frozen; halt stays 1 every cycle until reset.
  - No register or memory writes while halted.
  - cycle_count continues to increment.
- Reset mid-execution aborts the current instruction; no partial writes.

## Structure
- Package proc_pkg: opcode and func constants, and the width localparams (WORD = 16, REG_BITS = 3).
- Sub-module proc_regfile: 8×16, two asynchronous read ports, one write port written on the rising edge, asynchronous active-low clear.
- Remaining logic lives in proc_hier:
  - decoder
  - ALU
  - next-PC / branch unit
  - cycle counter

## Test plan
- Reset, then LBI R1,0x7F; LBI R2,0x80 -> R1 = 0x007F, R2 = 0xFF80; pc = 0, 2; reg_write = 1.
- ADDI R3,R1,−1; SUB R4=R2−R1 -> write_data 0x007E, then 0xFF01.
- LBI R5,0x10; ST R1→[R5+2]; LD R6←[R5+2] -> mem_write = 1, mem_address = 0x0012, mem_data = 0x007F; then R6 = 0x007F with mem_read = 1.
- STU R1→[R5+4] -> mem_address 0x0014, write_register 5, write_data 0x0014.
- BEQZ R0 (= 0) with imm 4 at PC 0x20 -> next pc 0x26. BNEZ not taken -> PC + 2. J −2 -> jumps to self.
- HALT at PC 0x30 -> halt = 1 and pc stays 0x30 for ≥3 cycles. Then pulse rst_n low mid-cycle -> pc = 0 and cycle_count = 0 asynchronously.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants for the proc_hier single-cycle core: widths, opcodes and
// R-type function codes.
package proc_pkg;

  localparam int WORD     = 16;
  localparam int REG_BITS = 3;
  localparam int NREGS    = 1 << REG_BITS;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_RTYPE = 5'b11011;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;

endpackage

// File: rtl/proc_regfile.sv
// 8x16 register file: two asynchronous read ports, one rising-edge write
// port, asynchronous active-low clear of every register.
module proc_regfile
  import proc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [REG_BITS-1:0] ra_i,
  input  logic [REG_BITS-1:0] rb_i,
  output logic [WORD-1:0]     rdata_a_o,
  output logic [WORD-1:0]     rdata_b_o,
  input  logic                we_i,
  input  logic [REG_BITS-1:0] waddr_i,
  input  logic [WORD-1:0]     wdata_i
);

  logic [WORD-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[ra_i];
  assign rdata_b_o = regs_q[rb_i];

endmodule

// File: rtl/proc_hier.sv
// Single-cycle 16-bit core: decode, ALU, next-PC unit and cycle counter
// around proc_regfile, with a combinational commit-trace port.
module proc_hier
  import proc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  output logic [WORD-1:0]     imem_addr,
  input  logic [WORD-1:0]     imem_rdata,
  output logic [WORD-1:0]     dmem_addr,
  output logic [WORD-1:0]     dmem_wdata,
  output logic                dmem_wen,
  output logic                dmem_ren,
  input  logic [WORD-1:0]     dmem_rdata,
  output logic [WORD-1:0]     pc,
  output logic [WORD-1:0]     inst,
  output logic                reg_write,
  output logic [REG_BITS-1:0] write_register,
  output logic [WORD-1:0]     write_data,
  output logic                mem_read,
  output logic                mem_write,
  output logic [WORD-1:0]     mem_address,
  output logic [WORD-1:0]     mem_data,
  output logic                halt,
  output logic [31:0]         cycle_count
);

  logic [WORD-1:0]     pc_q, pc_d;
  logic [31:0]         cycle_q;
  logic [4:0]          opcode;
  logic [1:0]          func;
  logic [REG_BITS-1:0] rs, rt_rd, rd_r;
  logic [WORD-1:0]     imm5_s, imm5_z, imm8_s, imm11_s;
  logic [WORD-1:0]     rs_val, rt_val;
  logic [WORD-1:0]     alu_res, wdata, pc_plus2;
  logic [REG_BITS-1:0] waddr;
  logic                rf_we, mem_we, mem_re, is_halt, take_br, is_jump;
  logic                rf_we_g;

  assign opcode  = imem_rdata[15:11];
  assign rs      = imem_rdata[10:8];
  assign rt_rd   = imem_rdata[7:5];
  assign rd_r    = imem_rdata[4:2];
  assign func    = imem_rdata[1:0];
  assign imm5_s  = {{11{imem_rdata[4]}}, imem_rdata[4:0]};
  assign imm5_z  = {11'b0, imem_rdata[4:0]};
  assign imm8_s  = {{8{imem_rdata[7]}}, imem_rdata[7:0]};
  assign imm11_s = {{5{imem_rdata[10]}}, imem_rdata[10:0]};

  always_comb begin
    alu_res = '0;
    wdata   = '0;
    waddr   = rt_rd;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    is_halt = 1'b0;
    take_br = 1'b0;
    is_jump = 1'b0;
    case (opcode)
      OP_HALT:  is_halt = 1'b1;
      OP_ADDI:  begin alu_res = rs_val + imm5_s;    rf_we = 1'b1; wdata = alu_res; end
      OP_SUBI:  begin alu_res = imm5_s - rs_val;    rf_we = 1'b1; wdata = alu_res; end
      OP_XORI:  begin alu_res = rs_val ^ imm5_z;    rf_we = 1'b1; wdata = alu_res; end
      OP_ANDNI: begin alu_res = rs_val & ~imm5_z;   rf_we = 1'b1; wdata = alu_res; end
      OP_ST:    begin alu_res = rs_val + imm5_s;    mem_we = 1'b1; end
      OP_LD:    begin
        alu_res = rs_val + imm5_s;
        mem_re  = 1'b1;
        rf_we   = 1'b1;
        wdata   = dmem_rdata;
      end
      // Store-with-update writes the effective address back into Rs.
      OP_STU:   begin
        alu_res = rs_val + imm5_s;
        mem_we  = 1'b1;
        rf_we   = 1'b1;
        waddr   = rs;
        wdata   = alu_res;
      end
      OP_RTYPE: begin
        case (func)
          FN_ADD:  alu_res = rs_val + rt_val;
          FN_SUB:  alu_res = rt_val - rs_val;
          FN_XOR:  alu_res = rs_val ^ rt_val;
          default: alu_res = rs_val & ~rt_val;
        endcase
        rf_we = 1'b1;
        waddr = rd_r;
        wdata = alu_res;
      end
      OP_LBI:   begin rf_we = 1'b1; waddr = rs; wdata = imm8_s; end
      OP_BEQZ:  take_br = (rs_val == '0);
      OP_BNEZ:  take_br = (rs_val != '0);
      OP_J:     is_jump = 1'b1;
      default:  ;
    endcase
  end

  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    pc_d = pc_plus2;
    if (is_halt)      pc_d = pc_q;
    else if (take_br) pc_d = pc_plus2 + imm8_s;
    else if (is_jump) pc_d = pc_plus2 + imm11_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      cycle_q <= '0;
    end else begin
      pc_q    <= pc_d;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Strobes are masked by rst_n so nothing commits or reports while in reset.
  assign rf_we_g = rf_we & rst_n;

  proc_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ra_i      (rs),
    .rb_i      (rt_rd),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val),
    .we_i      (rf_we_g),
    .waddr_i   (waddr),
    .wdata_i   (wdata)
  );

  assign imem_addr      = pc_q;
  assign dmem_addr      = alu_res;
  assign dmem_wdata     = rt_val;
  assign dmem_wen       = mem_we & rst_n;
  assign dmem_ren       = mem_re & rst_n;
  assign pc             = pc_q;
  assign inst           = imem_rdata;
  assign reg_write      = rf_we_g;
  assign write_register = waddr;
  assign write_data     = wdata;
  assign mem_read       = dmem_ren;
  assign mem_write      = dmem_wen;
  assign mem_address    = dmem_addr;
  assign mem_data       = dmem_wdata;
  assign halt           = is_halt & rst_n;
  assign cycle_count    = cycle_q;

endmodule

// File: tb/tb_proc_hier.sv
// Directed program bench for proc_hier with bench-side instruction and data
// memories and a queue of expected stores.
module tb_proc_hier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_wen, dmem_ren;
  logic [15:0] pc, inst, write_data, mem_address, mem_data;
  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_register;
  logic [31:0] cycle_count;

  logic [15:0] imem [0:63];
  logic [15:0] dmem [0:127];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  proc_hier dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wen(dmem_wen),
    .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata),
    .pc(pc), .inst(inst), .reg_write(reg_write),
    .write_register(write_register), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_data(mem_data),
    .halt(halt), .cycle_count(cycle_count)
  );

  assign imem_rdata = imem[imem_addr[6:1]];
  assign dmem_rdata = dmem[dmem_addr[7:1]];

  always @(posedge clk) begin
    if (dmem_wen) dmem[dmem_addr[7:1]] <= dmem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rs,
                                        input logic [2:0] rd, input logic [4:0] imm);
    return {op, rs, rd, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [1:0] fn);
    return {5'b11011, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] enc_b(input logic [4:0] op, input logic [2:0] rs,
                                        input logic [7:0] imm);
    return {op, rs, imm};
  endfunction

  // driver tasks
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [2:0] reg_idx, input logic [15:0] val);
    check({tag, "_we"}, reg_write, 1);
    check({tag, "_wreg"}, write_register, reg_idx);
    check({tag, "_wdata"}, write_data, val);
  endtask

  task automatic check_store(input string tag);
    logic [31:0] e;
    check({tag, "_memw"}, mem_write, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, {mem_address, mem_data}, 32'hDEAD_DEAD);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_addr_data"}, {mem_address, mem_data}, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 16'h0800;
    for (int i = 0; i < 128; i++) dmem[i] = 16'h0000;
    imem[8'h00 >> 1] = enc_b(5'b11000, 3'd1, 8'h7F);
    imem[8'h02 >> 1] = enc_b(5'b11000, 3'd2, 8'h80);
    imem[8'h04 >> 1] = enc_i(5'b01000, 3'd1, 3'd3, 5'h1F);
    imem[8'h06 >> 1] = enc_r(3'd1, 3'd2, 3'd4, 2'b01);
    imem[8'h08 >> 1] = enc_b(5'b11000, 3'd5, 8'h10);
    imem[8'h0A >> 1] = enc_i(5'b10000, 3'd5, 3'd1, 5'd2);
    imem[8'h0C >> 1] = enc_i(5'b10001, 3'd5, 3'd6, 5'd2);
    imem[8'h0E >> 1] = enc_i(5'b10011, 3'd5, 3'd1, 5'd4);
    imem[8'h10 >> 1] = enc_i(5'b01010, 3'd1, 3'd7, 5'h1F);
    imem[8'h12 >> 1] = enc_i(5'b01011, 3'd1, 3'd7, 5'h0F);
    imem[8'h14 >> 1] = enc_i(5'b01001, 3'd1, 3'd7, 5'd3);
    imem[8'h16 >> 1] = enc_r(3'd1, 3'd2, 3'd7, 2'b00);
    imem[8'h18 >> 1] = enc_r(3'd3, 3'd2, 3'd7, 2'b10);
    imem[8'h1A >> 1] = enc_r(3'd4, 3'd1, 3'd7, 2'b11);
    imem[8'h1C >> 1] = enc_i(5'b01000, 3'd5, 3'd7, 5'd1);
    imem[8'h1E >> 1] = 16'hF800;
    imem[8'h20 >> 1] = enc_b(5'b01100, 3'd0, 8'h04);
    imem[8'h22 >> 1] = enc_b(5'b11000, 3'd0, 8'h01);
    imem[8'h24 >> 1] = enc_b(5'b11000, 3'd0, 8'h01);
    imem[8'h26 >> 1] = enc_b(5'b01101, 3'd0, 8'h10);
    imem[8'h28 >> 1] = enc_b(5'b01101, 3'd1, 8'h02);
    imem[8'h2C >> 1] = {5'b00100, 11'd2};
    imem[8'h30 >> 1] = 16'h0000;
    exp_q.push_back({16'h0012, 16'h007F});
    exp_q.push_back({16'h0014, 16'h007F});

    rst_n = 1'b0;
    #3;
    check("rst_pc", pc, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_we", reg_write, 0);
    check("rst_halt", halt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    check("lbi1_pc", pc, 16'h0000);
    check("lbi1_cycle", cycle_count, 0);
    check_wr("lbi1", 3'd1, 16'h007F);
    adv(); check("lbi2_pc", pc, 16'h0002); check_wr("lbi2", 3'd2, 16'hFF80);
    adv(); check_wr("addi", 3'd3, 16'h007E);
    adv(); check_wr("sub", 3'd4, 16'hFF01);
    adv(); check_wr("lbi5", 3'd5, 16'h0010);
    adv(); check_store("st"); check("st_we", reg_write, 0); check("st_memr", mem_read, 0);
    adv(); check("ld_memr", mem_read, 1); check("ld_memw", mem_write, 0);
    check_wr("ld", 3'd6, 16'h007F);
    adv(); check_store("stu"); check_wr("stu", 3'd5, 16'h0014);
    adv(); check_wr("xori", 3'd7, 16'h0060);
    adv(); check_wr("andni", 3'd7, 16'h0070);
    adv(); check_wr("subi", 3'd7, 16'hFF84);
    adv(); check_wr("add", 3'd7, 16'hFFFF);
    adv(); check_wr("xor", 3'd7, 16'hFFFE);
    adv(); check_wr("andn", 3'd7, 16'hFF00);
    adv(); check_wr("addi_r5", 3'd7, 16'h0015);
    adv(); check("badop_we", reg_write, 0); check("badop_memw", mem_write, 0);
    adv(); check("beqz_pc", pc, 16'h0020); check("beqz_we", reg_write, 0);
    adv(); check("beqz_taken", pc, 16'h0026);
    adv(); check("bnez_not_taken", pc, 16'h0028);
    adv(); check("bnez_taken", pc, 16'h002C);
    adv(); check("j_fwd", pc, 16'h0030);
    check("halt_set", halt, 1);
    check("halt_cycle", cycle_count, 20);
    for (int i = 1; i <= 3; i++) begin
      adv();
      check("halt_pc", pc, 16'h0030);
      check("halt_hold", halt, 1);
      check("halt_we", reg_write, 0);
      check("halt_memw", mem_write, 0);
    end
    check("halt_cycle_run", cycle_count, 23);
    check("exp_q_empty", exp_q.size(), 0);
    check("dmem_0014", dmem[8'h14 >> 1], 16'h007F);

    // mid-cycle async reset, then a short program proving registers cleared
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_pc", pc, 0);
    check("mrst_cycle", cycle_count, 0);
    check("mrst_halt", halt, 0);
    check("mrst_we", reg_write, 0);
    imem[0] = enc_b(5'b01100, 3'd1, 8'h02);
    imem[2] = {5'b00100, 11'h7FE};
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_pc", pc, 0);
    adv(); check("r1_cleared_br", pc, 16'h0004); check("post_cycle", cycle_count, 1);
    adv(); check("j_self", pc, 16'h0004);
    adv(); check("j_self2", pc, 16'h0004); check("post_cycle3", cycle_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
